// File: rtl/fetch_dispatch_queue.sv
// In-order fetch->dispatch circular queue with compacting multi-lane enqueue and prefix take.
// Define FDQ_BYPASS_EN for a same-cycle fetch->dispatch path when the queue is empty.
module fetch_dispatch_queue #(
    parameter int unsigned IN_WAYS  = 2,
    parameter int unsigned OUT_WAYS = 2,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned XLEN     = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [IN_WAYS-1:0]            fetch_valid,
    input  logic [IN_WAYS*XLEN-1:0]       fetch_pc,
    input  logic [IN_WAYS*XLEN-1:0]       fetch_npc,
    input  logic [IN_WAYS*32-1:0]         fetch_inst,
    output logic                          fetch_ready,
    output logic [OUT_WAYS-1:0]           disp_valid,
    output logic [OUT_WAYS*XLEN-1:0]      disp_pc,
    output logic [OUT_WAYS*XLEN-1:0]      disp_npc,
    output logic [OUT_WAYS*32-1:0]        disp_inst,
    input  logic [$clog2(OUT_WAYS+1)-1:0] disp_take,
    output logic [$clog2(DEPTH):0]        count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned KW = $clog2(IN_WAYS + 1);
    localparam int unsigned MW = (IN_WAYS > OUT_WAYS) ? IN_WAYS : OUT_WAYS;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [XLEN-1:0] pc_q   [DEPTH];
    logic [XLEN-1:0] pc_d   [DEPTH];
    logic [XLEN-1:0] npc_q  [DEPTH];
    logic [XLEN-1:0] npc_d  [DEPTH];
    logic [31:0]     inst_q [DEPTH];
    logic [31:0]     inst_d [DEPTH];
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d, widx;
    logic [CW-1:0]   count_q, count_d;

    logic [KW-1:0]   rank [IN_WAYS];
    logic [KW-1:0]   k;
    logic [MW-1:0]   cmp_valid;
    logic [XLEN-1:0] cmp_pc   [MW];
    logic [XLEN-1:0] cmp_npc  [MW];
    logic [31:0]     cmp_inst [MW];
    logic [CW-1:0]   k_c, take_c, take_n, byp_n, wr_n;
    logic            bypass, enq;

    // Rank of each valid lane among the valid lanes (its compacted slot).
    always_comb begin
        k = '0;
        for (int i = 0; i < IN_WAYS; i++) begin
            rank[i] = k;
            k       = k + KW'(fetch_valid[i]);
        end
    end

    always_comb begin
        cmp_valid = '0;
        for (int j = 0; j < MW; j++) begin
            cmp_pc[j]   = '0;
            cmp_npc[j]  = '0;
            cmp_inst[j] = NOP;
        end
        for (int j = 0; j < IN_WAYS; j++) begin
            cmp_valid[j] = KW'(j) < k;
            for (int i = j; i < IN_WAYS; i++) begin
                if (fetch_valid[i] && rank[i] == KW'(j)) begin
                    cmp_pc[j]   = fetch_pc[i*XLEN +: XLEN];
                    cmp_npc[j]  = fetch_npc[i*XLEN +: XLEN];
                    cmp_inst[j] = fetch_inst[i*32 +: 32];
                end
            end
        end
    end

    always_comb begin
        pc_d       = pc_q;
        npc_d      = npc_q;
        inst_d     = inst_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        widx       = '0;
        k_c        = CW'(k);
        take_c     = CW'(disp_take);
        take_n     = '0;
        byp_n      = '0;
        wr_n       = k_c;
        disp_valid = '0;
        disp_pc    = '0;
        disp_npc   = '0;
        disp_inst  = {OUT_WAYS{NOP}};
        count      = count_q;
        fetch_ready = count_q <= CW'(DEPTH - IN_WAYS);
`ifdef FDQ_BYPASS_EN
        bypass = (count_q == '0) && !flush;
`else
        bypass = 1'b0;
`endif
        enq = fetch_ready && !flush;

        // Dispatch view: oldest entries, or the compacted fetch group when bypassing.
        for (int i = 0; i < OUT_WAYS; i++) begin
            if (bypass) begin
                if (cmp_valid[i]) begin
                    disp_valid[i]               = 1'b1;
                    disp_pc[i*XLEN +: XLEN]     = cmp_pc[i];
                    disp_npc[i*XLEN +: XLEN]    = cmp_npc[i];
                    disp_inst[i*32 +: 32]       = cmp_inst[i];
                end
            end else if (CW'(i) < count_q) begin
                disp_valid[i]               = 1'b1;
                disp_pc[i*XLEN +: XLEN]     = pc_q[head_q + PW'(i)];
                disp_npc[i*XLEN +: XLEN]    = npc_q[head_q + PW'(i)];
                disp_inst[i*32 +: 32]       = inst_q[head_q + PW'(i)];
            end
        end

        if (bypass) begin
            byp_n = (take_c < k_c) ? take_c : k_c;
            wr_n  = k_c - byp_n;
        end else begin
            take_n = (take_c < count_q) ? take_c : count_q;
        end

        // Bypassed-and-consumed lanes are skipped; the rest land at tail onward.
        for (int j = 0; j < IN_WAYS; j++) begin
            if (enq && CW'(j) >= byp_n && CW'(j) < k_c) begin
                widx         = tail_q + PW'(CW'(j) - byp_n);
                pc_d[widx]   = cmp_pc[j];
                npc_d[widx]  = cmp_npc[j];
                inst_d[widx] = cmp_inst[j];
            end
        end

        head_d  = head_q + PW'(take_n);
        count_d = count_q - take_n;
        if (enq) begin
            tail_d  = tail_q + PW'(wr_n);
            count_d = count_d + wr_n;
        end
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        pc_q   <= pc_d;
        npc_q  <= npc_d;
        inst_q <= inst_d;
    end
endmodule

// File: tb/tb_fetch_dispatch_queue.sv
// Directed + randomized bench for fetch_dispatch_queue against a queue-based reference model.
module tb_fetch_dispatch_queue;
    localparam int unsigned IW = 2;
    localparam int unsigned OW = 2;
    localparam int unsigned D  = 8;
    localparam int unsigned XL = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FDQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset, flush;
    logic [IW-1:0]     fetch_valid;
    logic [IW*XL-1:0]  fetch_pc, fetch_npc;
    logic [IW*32-1:0]  fetch_inst;
    logic              fetch_ready;
    logic [OW-1:0]     disp_valid;
    logic [OW*XL-1:0]  disp_pc, disp_npc;
    logic [OW*32-1:0]  disp_inst;
    logic [1:0]        disp_take;
    logic [3:0]        count;

    fetch_dispatch_queue #(.IN_WAYS(IW), .OUT_WAYS(OW), .DEPTH(D), .XLEN(XL)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_npc(fetch_npc),
        .fetch_inst(fetch_inst), .fetch_ready(fetch_ready),
        .disp_valid(disp_valid), .disp_pc(disp_pc), .disp_npc(disp_npc),
        .disp_inst(disp_inst), .disp_take(disp_take), .count(count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    ent_t        inc[$];
    ent_t        lane_e[IW];
    logic [31:0] oq[$];
    int          compared = 0;
    int          mismatched = 0;

    function automatic ent_t mk(input logic [31:0] pc);
        ent_t e;
        e.pc   = pc;
        e.npc  = pc + 32'd4;
        e.inst = 32'hA500_0000 ^ pc;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build_inc();
        inc.delete();
        for (int l = 0; l < IW; l++)
            if (fetch_valid[l]) inc.push_back(lane_e[l]);
    endtask

    // Expected dispatch view: queue head, or the incoming group on an empty bypassing queue.
    task automatic check_view();
        ent_t v[$];
        int   sz;
        logic ev;
        build_inc();
        sz = mq.size();
        if (sz > 0) v = mq;
        else if (BYP && !flush) v = inc;
        chk("count", 64'(count), 64'(sz));
        chk("fetch_ready", 64'(fetch_ready), 64'((int'(D) - sz) >= int'(IW)));
        for (int i = 0; i < OW; i++) begin
            ev = i < v.size();
            chk($sformatf("disp_valid%0d", i), 64'(disp_valid[i]), 64'(ev));
            chk($sformatf("disp_pc%0d", i), 64'(disp_pc[i*XL +: XL]), ev ? 64'(v[i].pc) : 64'd0);
            chk($sformatf("disp_npc%0d", i), 64'(disp_npc[i*XL +: XL]), ev ? 64'(v[i].npc) : 64'd0);
            chk($sformatf("disp_inst%0d", i), 64'(disp_inst[i*32 +: 32]), ev ? 64'(v[i].inst) : 64'(NOP));
        end
    endtask

    task automatic update_model();
        int t, sz;
        build_inc();
        sz = mq.size();
        if (reset || flush) begin
            mq.delete();
        end else if (BYP && sz == 0) begin
            t = (int'(disp_take) < inc.size()) ? int'(disp_take) : inc.size();
            for (int i = t; i < inc.size(); i++) mq.push_back(inc[i]);
        end else begin
            t = (int'(disp_take) < sz) ? int'(disp_take) : sz;
            for (int i = 0; i < t; i++) void'(mq.pop_front());
            if ((int'(D) - sz) >= int'(IW))
                for (int i = 0; i < inc.size(); i++) mq.push_back(inc[i]);
        end
    endtask

    task automatic drive(input logic [1:0] fv, input logic [31:0] p0, input logic [31:0] p1,
                         input int take, input logic fl);
        lane_e[0] = mk(p0);
        lane_e[1] = mk(p1);
        fetch_valid = fv;
        for (int l = 0; l < IW; l++) begin
            fetch_pc[l*XL +: XL]   = lane_e[l].pc;
            fetch_npc[l*XL +: XL]  = lane_e[l].npc;
            fetch_inst[l*32 +: 32] = lane_e[l].inst;
        end
        disp_take = 2'(take);
        flush = fl;
    endtask

    task automatic idle_inputs();
        fetch_valid = '0;
        disp_take   = '0;
        flush       = 1'b0;
    endtask

    // One cycle: drive, check the view before the edge, record what the DUT dispatched, advance the model.
    task automatic step(input logic [1:0] fv, input logic [31:0] p0, input logic [31:0] p1,
                        input int take, input logic fl);
        int nv, tt;
        drive(fv, p0, p1, take, fl);
        @(negedge clock);
        check_view();
        nv = 0;
        for (int i = 0; i < OW; i++) nv += int'(disp_valid[i]);
        tt = (take < nv) ? take : nv;
        for (int i = 0; i < tt; i++) oq.push_back(disp_pc[i*XL +: XL]);
        @(posedge clock);
        update_model();
        #1;
        idle_inputs();
    endtask

    initial begin
        logic [1:0]  fv;
        logic [31:0] p[2];
        logic [31:0] next_pc, np;
        int          take;
        bit          accepted;

        reset = 1'b1;
        drive(2'b00, 32'h0, 32'h0, 0, 1'b0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset values
        @(negedge clock);
        check_view();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ready", 64'(fetch_ready), 64'd1);
        chk("rst_valid", 64'(disp_valid), 64'd0);
        chk("rst_inst", 64'(disp_inst), {NOP, NOP});
        @(posedge clock);
        #1;

        // Two-lane enqueue
        step(2'b11, 32'h0, 32'h4, 0, 1'b0);
        chk("t2_count", 64'(count), 64'd2);
        chk("t2_valid", 64'(disp_valid), 64'd3);
        chk("t2_pc", 64'(disp_pc), {32'h4, 32'h0});

        // Sparse lane enqueue with concurrent take
        step(2'b01, 32'h8, 32'h0, 0, 1'b0);
        step(2'b10, 32'hDEAD0, 32'hC, 1, 1'b0);
        chk("t3_count", 64'(count), 64'd3);
        chk("t3_pc0", 64'(disp_pc[31:0]), 64'h4);
        chk("t3_pc1", 64'(disp_pc[63:32]), 64'h8);
        step(2'b00, 32'h0, 32'h0, 2, 1'b0);
        chk("t3_take2_pc0", 64'(disp_pc[31:0]), 64'hC);
        chk("t3_take2_valid", 64'(disp_valid), 64'd1);

        // Fill to 7, group dropped, take does not raise ready in the same cycle
        step(2'b11, 32'h10, 32'h14, 0, 1'b0);
        step(2'b11, 32'h18, 32'h1C, 0, 1'b0);
        step(2'b11, 32'h20, 32'h24, 0, 1'b0);
        chk("t4_count7", 64'(count), 64'd7);
        chk("t4_ready0", 64'(fetch_ready), 64'd0);
        step(2'b11, 32'h28, 32'h2C, 0, 1'b0);
        chk("t4_drop_count", 64'(count), 64'd7);
        drive(2'b11, 32'h28, 32'h2C, 2, 1'b0);
        @(negedge clock);
        check_view();
        chk("t4_ready_in_take", 64'(fetch_ready), 64'd0);
        @(posedge clock);
        update_model();
        #1;
        idle_inputs();
        chk("t4_count5", 64'(count), 64'd5);

        // Flush overrides enqueue and take
        step(2'b11, 32'h100, 32'h104, 2, 1'b1);
        chk("t6_count", 64'(count), 64'd0);
        chk("t6_valid", 64'(disp_valid), 64'd0);

        // Randomized stream of 40 sequential PCs
        oq.delete();
        next_pc = 32'h0;
        for (int cyc = 0; cyc < 3000 && oq.size() < 40; cyc++) begin
            fv = 2'($urandom);
            np = next_pc;
            for (int l = 0; l < IW; l++) begin
                if (fv[l] && np < 32'd160) begin
                    p[l] = np;
                    np   = np + 32'd4;
                end else begin
                    fv[l] = 1'b0;
                    p[l]  = $urandom;
                end
            end
            take = $urandom_range(0, 2);
            accepted = (int'(D) - mq.size()) >= int'(IW);
            step(fv, p[0], p[1], take, 1'b0);
            if (accepted) next_pc = np;
        end
        chk("t5_dispatched", 64'(oq.size()), 64'd40);
        for (int i = 0; i < oq.size() && i < 40; i++)
            chk($sformatf("t5_seq%0d", i), 64'(oq[i]), 64'(32'(i * 4)));

        // Drain, then take=2 with a single entry clamps to 1
        for (int i = 0; i < 20 && mq.size() > 0; i++) step(2'b00, 32'h0, 32'h0, 2, 1'b0);
        chk("drain_count", 64'(count), 64'd0);
        step(2'b01, 32'h200, 32'h0, 0, 1'b0);
        chk("clamp_pre", 64'(count), 64'd1);
        step(2'b00, 32'h0, 32'h0, 2, 1'b0);
        chk("clamp_post", 64'(count), 64'd0);

`ifdef FDQ_BYPASS_EN
        // Same-cycle bypass on an empty queue
        drive(2'b11, 32'h40, 32'h44, 1, 1'b0);
        @(negedge clock);
        check_view();
        chk("byp_pc0", 64'(disp_pc[31:0]), 64'h40);
        @(posedge clock);
        update_model();
        #1;
        idle_inputs();
        chk("byp_count", 64'(count), 64'd1);
        chk("byp_next_pc0", 64'(disp_pc[31:0]), 64'h44);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
